// File: rtl/ram_port_arbiter_pkg.sv
// Shared types and defaults for the RAM port arbiter.
package cpuf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    localparam int DEF_NREQ = 3;
    localparam int DEF_AW   = 4;
    localparam int DEF_DW   = 8;

    localparam int REQ_FETCH = 0;
    localparam int REQ_LOAD  = 1;
    localparam int REQ_WB    = 2;

endpackage

// File: rtl/ram_port_arbiter_rr_picker.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ... modulo NREQ
// and returns the first requesting index as a one-hot vector.
module rr_picker
    import cpuf_arb_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_win,
    output logic            o_any
);

    localparam int unsigned NREQ_U = NREQ;

    int unsigned w_best;
    int unsigned w_bidx;
    int unsigned w_dist;

    // Rank every requester by its distance after ptr; the nearest one wins.
    // Constant indexing keeps the loop free of variable bit-selects.
    always_comb begin
        w_best = NREQ_U;
        w_bidx = 0;
        w_dist = 0;
        for (int unsigned j = 0; j < NREQ_U; j++) begin
            w_dist = (j + 2 * NREQ_U - 1 - 32'(i_ptr)) % NREQ_U;
            if (i_req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_bidx = j;
            end
        end
        o_win = '0;
        for (int unsigned j = 0; j < NREQ_U; j++) begin
            o_win[j] = i_req[j] && (w_bidx == j);
        end
        o_any = |i_req;
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one registered RAM port between NREQ
// requesters (fetch, operand load, write-back). Optional write protection
// of addresses below PROT_LIMIT is enabled by defining RAM_ARB_WPROT_EN.
module ram_port_arbiter
    import cpuf_arb_pkg::*;
#(
    parameter int NREQ       = DEF_NREQ,
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int PROT_LIMIT = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               halt,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic               busy,
    output logic [AW-1:0]      mem_addr,
    output logic               mem_we,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata,
    output logic               err
);

    localparam int          PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [AW:0] PLIM = (AW+1)'(PROT_LIMIT);

    arb_state_t      r_state;
    arb_state_t      w_next;
    logic [PW-1:0]   r_ptr;
    logic [NREQ-1:0] r_win;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_rvalid;
    logic            r_wr;
    logic            r_prot;
    logic            r_err;
    logic            r_mem_we;
    logic [AW-1:0]   r_mem_addr;
    logic [DW-1:0]   r_mem_wdata;

    logic [NREQ-1:0] w_mask_req;
    logic [NREQ-1:0] w_pick;
    logic            w_any;
    logic            w_grant;
    logic [PW-1:0]   w_idx;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_wdata;
    logic            w_sel_we;
    logic            w_prot_en;
    logic            w_prot_hit;

`ifdef RAM_ARB_WPROT_EN
    assign w_prot_en = 1'b1;
`else
    assign w_prot_en = 1'b0;
`endif

    // The requester being answered in RESP sits out that arbitration round.
    assign w_mask_req = (r_state == RESP) ? (req & ~r_win) : req;

    rr_picker #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_picker (
        .i_req (w_mask_req),
        .i_ptr (r_ptr),
        .o_win (w_pick),
        .o_any (w_any)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic: grants can start from IDLE or back-to-back from RESP.
    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = w_grant ? GRANT : IDLE;
            GRANT:   w_next = RESP;
            RESP:    w_next = w_grant ? GRANT : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Grant decision and winner's request fields muxed onto the port.
    always_comb begin
        w_grant     = ((r_state == IDLE) || (r_state == RESP)) && !halt && w_any;
        w_idx       = '0;
        w_sel_addr  = '0;
        w_sel_we    = 1'b0;
        w_sel_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (w_pick[i]) begin
                w_idx       = PW'(i);
                w_sel_addr  = addr[i*AW +: AW];
                w_sel_we    = we[i];
                w_sel_wdata = wdata[i*DW +: DW];
            end
        end
        w_prot_hit = w_prot_en && w_sel_we && ({1'b0, w_sel_addr} < PLIM);
    end

    // Registered memory port, pulses and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr       <= PW'(NREQ - 1);
            r_win       <= '0;
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_wr        <= 1'b0;
            r_prot      <= 1'b0;
            r_err       <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_err    <= 1'b0;
            r_mem_we <= 1'b0;
            if (w_grant) begin
                r_gnt       <= w_pick;
                r_win       <= w_pick;
                r_ptr       <= w_idx;
                r_mem_addr  <= w_sel_addr;
                r_mem_we    <= w_sel_we && !w_prot_hit;
                r_mem_wdata <= w_sel_wdata;
                r_wr        <= w_sel_we;
                r_prot      <= w_prot_hit;
            end
            if (r_state == GRANT) begin
                r_rvalid <= r_win;
                r_err    <= r_prot;
            end
        end
    end

    // RAM read data arrives in RESP, so it is steered straight through.
    assign rdata     = ((|r_rvalid) && !r_wr) ? mem_rdata : '0;
    assign gnt       = r_gnt;
    assign rvalid    = r_rvalid;
    assign busy      = (r_state == GRANT) || (r_state == RESP);
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: directed vector table, write-protect
// sequence (when RAM_ARB_WPROT_EN is defined) and randomized traffic checked
// against a transaction-level reference model.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        halt = 1'b0;
    logic [2:0]  req = '0;
    logic [2:0]  we = '0;
    logic [11:0] addr = '0;
    logic [23:0] wdata = '0;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [7:0]  rdata;
    logic        busy;
    logic [3:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = '0;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    ram_port_arbiter #(
        .NREQ       (3),
        .AW         (4),
        .DW         (8),
        .PROT_LIMIT (9)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .halt      (halt),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    always #5 clk = ~clk;

    // 16x8 RAM with one-cycle registered read; preloaded with 0x85+i.
    logic [7:0] ram [16];
    logic       ram_init = 1'b1;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 16; i++) ram[i] <= 8'(8'h85 + i);
            ram_init <= 1'b0;
        end else begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Transaction view: an access is granted in one cycle and answered in the
    // next; a new grant needs the previous cycle to be free of a grant, halt
    // low, and picks the first eligible requester after the last winner.
    logic [7:0]  shadow [16];
    int          m_last = 2;
    logic [2:0]  m_pg = '0, m_prv = '0, m_preq = '0, m_pwe = '0;
    logic        m_phalt = 1'b0, m_prst = 1'b1;
    logic [11:0] m_pad = '0;
    logic [23:0] m_pwd = '0;
    logic        t_we = 1'b0, t_prot = 1'b0;
    logic [3:0]  t_addr = '0;
    logic [3:0]  m_maddr = '0;
    logic [7:0]  m_mwd = '0;
    logic        chk_on = 1'b0;

    function automatic logic is_prot(input logic wr, input logic [3:0] a);
`ifdef RAM_ARB_WPROT_EN
        return wr && (a < 4'd9);
`else
        return 1'b0 && wr && (a == 4'd0);
`endif
    endfunction

    task automatic model_step();
        logic [2:0] e_gnt, e_rv, elig;
        logic [7:0] e_rd;
        logic       e_we, e_err, e_busy, n_we, n_prot;
        logic [3:0] n_addr;
        int         w, c;
        e_gnt = '0; e_rv = '0; e_rd = '0; e_we = 1'b0; e_err = 1'b0; w = -1;
        n_we = 1'b0; n_prot = 1'b0; n_addr = '0;
        if (!m_prst) begin
            e_rv = m_pg;
            if (e_rv != 0) begin
                e_rd  = t_we ? 8'h00 : shadow[t_addr];
                e_err = t_prot;
            end
            if (m_pg == 0 && !m_phalt) begin
                elig = m_preq & ~m_prv;
                for (int k = 1; k <= 3; k++) begin
                    c = (m_last + k) % 3;
                    if (w < 0 && elig[c]) w = c;
                end
                if (w >= 0) begin
                    e_gnt[w] = 1'b1;
                    n_we     = m_pwe[w];
                    n_addr   = m_pad[w*4 +: 4];
                    n_prot   = is_prot(n_we, n_addr);
                    e_we     = n_we && !n_prot;
                    m_maddr  = n_addr;
                    m_mwd    = m_pwd[w*8 +: 8];
                end
            end
        end
        e_busy = (|e_gnt) || (|e_rv);
        if (chk_on) begin
            chk("m_gnt",       32'(gnt),       32'(e_gnt));
            chk("m_rvalid",    32'(rvalid),    32'(e_rv));
            chk("m_rdata",     32'(rdata),     32'(e_rd));
            chk("m_mem_we",    32'(mem_we),    32'(e_we));
            chk("m_err",       32'(err),       32'(e_err));
            chk("m_busy",      32'(busy),      32'(e_busy));
            chk("m_mem_addr",  32'(mem_addr),  32'(m_maddr));
            chk("m_mem_wdata", 32'(mem_wdata), 32'(m_mwd));
        end
        if (e_we) shadow[m_maddr] = m_mwd;
        if (w >= 0) begin
            m_last = w; t_we = n_we; t_addr = n_addr; t_prot = n_prot;
        end
        m_pg = e_gnt; m_prv = e_rv; m_preq = req; m_pwe = we; m_pad = addr;
        m_pwd = wdata; m_phalt = halt; m_prst = reset;
        if (reset) begin
            m_last = 2; m_maddr = '0; m_mwd = '0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        chk;
        logic        rst;
        logic        hlt;
        logic [2:0]  rq;
        logic [2:0]  wen;
        logic [11:0] ad;
        logic [23:0] wd;
        logic [2:0]  e_gnt;
        logic [2:0]  e_rv;
        logic [7:0]  e_rd;
        logic        e_mwe;
    } vec_t;

    function automatic vec_t mk(input logic ck, input logic rs, input logic hl,
                                input logic [2:0] rq, input logic [2:0] wn,
                                input logic [11:0] ad, input logic [23:0] wd,
                                input logic [2:0] eg, input logic [2:0] ev,
                                input logic [7:0] erd, input logic emwe);
        vec_t v;
        v.chk = ck; v.rst = rs; v.hlt = hl; v.rq = rq; v.wen = wn; v.ad = ad;
        v.wd = wd; v.e_gnt = eg; v.e_rv = ev; v.e_rd = erd; v.e_mwe = emwe;
        return v;
    endfunction

    vec_t tbl [40];

    // random-phase requester state
    logic [2:0] pend = '0, rvs = '0, grd = '0, cool = '0;
    logic       prev_rst = 1'b0;

    task automatic rand_cycle();
        @(posedge clk); #1;
        if (prev_rst) begin
            pend = '0; rvs = '0; grd = '0; cool = '0; req = '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (pend[i]) begin
                    if (rvs[i]) begin
                        req[i] = 1'b0; pend[i] = 1'b0; rvs[i] = 1'b0;
                        grd[i] = 1'b0; cool[i] = 1'b1;
                    end else if (rvalid[i]) begin
                        rvs[i] = 1'b1;
                    end else if (gnt[i]) begin
                        grd[i] = 1'b1;
                    end else if (!grd[i] && $urandom_range(15) == 0) begin
                        req[i] = 1'b0; pend[i] = 1'b0;
                    end
                end else if (cool[i]) begin
                    cool[i] = 1'b0;
                end else if ($urandom_range(2) == 0) begin
                    pend[i] = 1'b1;
                    req[i]  = 1'b1;
                    we[i]   = 1'($urandom_range(1));
                    addr[i*4 +: 4]  = 4'($urandom_range(15));
                    wdata[i*8 +: 8] = 8'($urandom);
                end
            end
        end
        if ($urandom_range(11) == 0) halt = ~halt;
        reset    = ($urandom_range(149) == 0);
        prev_rst = reset;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = 8'(8'h85 + i);

        //              ck rs hl rq      we      addr     wdata      gnt     rvalid  rdata mwe
        tbl[0]  = mk(0, 1, 0, 3'b000, 3'b000, 12'h000, 24'h000000, 3'b000, 3'b000, 8'h00, 0);
        // single read of addr 1
        tbl[1]  = mk(1, 0, 0, 3'b001, 3'b000, 12'h001, 24'h000000, 3'b000, 3'b000, 8'h00, 0);
        tbl[2]  = mk(1, 0, 0, 3'b001, 3'b000, 12'h001, 24'h000000, 3'b001, 3'b000, 8'h00, 0);
        tbl[3]  = mk(1, 0, 0, 3'b001, 3'b000, 12'h001, 24'h000000, 3'b000, 3'b001, 8'h86, 0);
        tbl[4]  = mk(1, 0, 0, 3'b000, 3'b000, 12'h000, 24'h000000, 3'b000, 3'b000, 8'h00, 0);
        // requester 2 writes 0x12 to F, requester 1 reads F back-to-back
        tbl[5]  = mk(1, 0, 0, 3'b100, 3'b100, 12'hF00, 24'h120000, 3'b000, 3'b000, 8'h00, 0);
        tbl[6]  = mk(1, 0, 0, 3'b100, 3'b100, 12'hF00, 24'h120000, 3'b100, 3'b000, 8'h00, 1);
        tbl[7]  = mk(1, 0, 0, 3'b110, 3'b100, 12'hFF0, 24'h120000, 3'b000, 3'b100, 8'h00, 0);
        tbl[8]  = mk(1, 0, 0, 3'b010, 3'b000, 12'h0F0, 24'h000000, 3'b010, 3'b000, 8'h00, 0);
        tbl[9]  = mk(1, 0, 0, 3'b010, 3'b000, 12'h0F0, 24'h000000, 3'b000, 3'b010, 8'h12, 0);
        tbl[10] = mk(1, 0, 0, 3'b000, 3'b000, 12'h000, 24'h000000, 3'b000, 3'b000, 8'h00, 0);
        // contention after reset: order 0,1,2,0
        tbl[11] = mk(1, 1, 0, 3'b000, 3'b000, 12'h000, 24'h000000, 3'b000, 3'b000, 8'h00, 0);
        tbl[12] = mk(1, 0, 0, 3'b111, 3'b000, 12'h753, 24'h000000, 3'b000, 3'b000, 8'h00, 0);
        tbl[13] = mk(1, 0, 0, 3'b111, 3'b000, 12'h753, 24'h000000, 3'b001, 3'b000, 8'h00, 0);
        tbl[14] = mk(1, 0, 0, 3'b111, 3'b000, 12'h753, 24'h000000, 3'b000, 3'b001, 8'h88, 0);
        tbl[15] = mk(1, 0, 0, 3'b111, 3'b000, 12'h753, 24'h000000, 3'b010, 3'b000, 8'h00, 0);
        tbl[16] = mk(1, 0, 0, 3'b111, 3'b000, 12'h753, 24'h000000, 3'b000, 3'b010, 8'h8A, 0);
        tbl[17] = mk(1, 0, 0, 3'b111, 3'b000, 12'h753, 24'h000000, 3'b100, 3'b000, 8'h00, 0);
        tbl[18] = mk(1, 0, 0, 3'b111, 3'b000, 12'h753, 24'h000000, 3'b000, 3'b100, 8'h8C, 0);
        tbl[19] = mk(1, 0, 0, 3'b111, 3'b000, 12'h753, 24'h000000, 3'b001, 3'b000, 8'h00, 0);
        tbl[20] = mk(1, 0, 0, 3'b001, 3'b000, 12'h753, 24'h000000, 3'b000, 3'b001, 8'h88, 0);
        tbl[21] = mk(1, 0, 0, 3'b000, 3'b000, 12'h000, 24'h000000, 3'b000, 3'b000, 8'h00, 0);
        // halt rises in GRANT of requester 1
        tbl[22] = mk(1, 0, 0, 3'b010, 3'b000, 12'h020, 24'h000000, 3'b000, 3'b000, 8'h00, 0);
        tbl[23] = mk(1, 0, 1, 3'b011, 3'b000, 12'h024, 24'h000000, 3'b010, 3'b000, 8'h00, 0);
        tbl[24] = mk(1, 0, 1, 3'b011, 3'b000, 12'h024, 24'h000000, 3'b000, 3'b010, 8'h87, 0);
        tbl[25] = mk(1, 0, 1, 3'b001, 3'b000, 12'h004, 24'h000000, 3'b000, 3'b000, 8'h00, 0);
        tbl[26] = mk(1, 0, 1, 3'b001, 3'b000, 12'h004, 24'h000000, 3'b000, 3'b000, 8'h00, 0);
        tbl[27] = mk(1, 0, 0, 3'b001, 3'b000, 12'h004, 24'h000000, 3'b000, 3'b000, 8'h00, 0);
        tbl[28] = mk(1, 0, 0, 3'b001, 3'b000, 12'h004, 24'h000000, 3'b001, 3'b000, 8'h00, 0);
        tbl[29] = mk(1, 0, 0, 3'b001, 3'b000, 12'h004, 24'h000000, 3'b000, 3'b001, 8'h89, 0);
        tbl[30] = mk(1, 0, 0, 3'b000, 3'b000, 12'h000, 24'h000000, 3'b000, 3'b000, 8'h00, 0);
        // reset in GRANT of a write, then a fresh read wins first
        tbl[31] = mk(1, 0, 0, 3'b001, 3'b001, 12'h00C, 24'h00005A, 3'b000, 3'b000, 8'h00, 0);
        tbl[32] = mk(1, 1, 0, 3'b001, 3'b001, 12'h00C, 24'h00005A, 3'b001, 3'b000, 8'h00, 1);
        tbl[33] = mk(1, 0, 0, 3'b001, 3'b000, 12'h00D, 24'h000000, 3'b000, 3'b000, 8'h00, 0);
        tbl[34] = mk(1, 0, 0, 3'b001, 3'b000, 12'h00D, 24'h000000, 3'b001, 3'b000, 8'h00, 0);
        tbl[35] = mk(1, 0, 0, 3'b001, 3'b000, 12'h00D, 24'h000000, 3'b000, 3'b001, 8'h92, 0);
        tbl[36] = mk(1, 0, 0, 3'b000, 3'b000, 12'h000, 24'h000000, 3'b000, 3'b000, 8'h00, 0);
        // request dropped while halted is never served
        tbl[37] = mk(1, 0, 1, 3'b001, 3'b000, 12'h003, 24'h000000, 3'b000, 3'b000, 8'h00, 0);
        tbl[38] = mk(1, 0, 0, 3'b000, 3'b000, 12'h000, 24'h000000, 3'b000, 3'b000, 8'h00, 0);
        tbl[39] = mk(1, 0, 0, 3'b000, 3'b000, 12'h000, 24'h000000, 3'b000, 3'b000, 8'h00, 0);

        for (int r = 0; r < 40; r++) begin
            @(posedge clk); #1;
            reset = tbl[r].rst; halt = tbl[r].hlt; req = tbl[r].rq;
            we = tbl[r].wen; addr = tbl[r].ad; wdata = tbl[r].wd;
            tick();
            chk_on = 1'b1;
            if (tbl[r].chk) begin
                chk("t_gnt",    32'(gnt),    32'(tbl[r].e_gnt));
                chk("t_rvalid", 32'(rvalid), 32'(tbl[r].e_rv));
                chk("t_rdata",  32'(rdata),  32'(tbl[r].e_rd));
                chk("t_mem_we", 32'(mem_we), 32'(tbl[r].e_mwe));
                if (tbl[r].rst && r == 32) chk("t_wdata_abort", 32'(mem_wdata), 32'h5A);
            end
        end
        chk("t_reset_addr", 32'(mem_addr), 32'h0D);

`ifdef RAM_ARB_WPROT_EN
        // protected write to 2 is suppressed and flagged; write to E is performed
        @(posedge clk); #1;
        req = 3'b100; we = 3'b100; addr = 12'h200; wdata = 24'hAA0000;
        tick();
        @(posedge clk); #1; tick();
        chk("p_gnt", 32'(gnt), 32'h4);
        chk("p_mem_we", 32'(mem_we), 32'h0);
        @(posedge clk); #1; tick();
        chk("p_rvalid", 32'(rvalid), 32'h4);
        chk("p_err", 32'(err), 32'h1);
        @(posedge clk); #1; req = '0; tick();
        chk("p_err_clr", 32'(err), 32'h0);
        @(posedge clk); #1;
        req = 3'b100; we = 3'b100; addr = 12'hE00; wdata = 24'h3C0000;
        tick();
        @(posedge clk); #1; tick();
        chk("p2_mem_we", 32'(mem_we), 32'h1);
        chk("p2_wdata", 32'(mem_wdata), 32'h3C);
        @(posedge clk); #1; tick();
        chk("p2_rvalid", 32'(rvalid), 32'h4);
        chk("p2_err", 32'(err), 32'h0);
        @(posedge clk); #1; req = '0; tick();
`endif

        // randomized traffic against the reference model
        @(posedge clk); #1;
        reset = 1'b1; halt = 1'b0; req = '0; we = '0;
        prev_rst = 1'b1;
        tick();
        for (int n = 0; n < 3000; n++) rand_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
